// File: rtl/fb_pixel_writer_if.sv
// Pixel stream, palette, vblank and frame buffer write port of fb_pixel_writer.
// slave = the writer, master = the PPU/display/frame buffer side driving it.
interface fb_pixel_writer_if #(
    parameter int ADDR_W = 16
);
    logic              frame_start_in;
    logic              px_valid_in;
    logic [1:0]        px_shade_in;
    logic              px_ready_out;
    logic [7:0]        palette_in;
    logic              vblank_in;
    logic              fb_en_out;
    logic              fb_we_out;
    logic [ADDR_W-1:0] fb_addr_out;
    logic [14:0]       fb_din_out;
    logic              display_bank_out;
    logic [7:0]        frame_count_out;

    modport slave (
        input  frame_start_in,
        input  px_valid_in,
        input  px_shade_in,
        input  palette_in,
        input  vblank_in,
        output px_ready_out,
        output fb_en_out,
        output fb_we_out,
        output fb_addr_out,
        output fb_din_out,
        output display_bank_out,
        output frame_count_out
    );

    modport master (
        output frame_start_in,
        output px_valid_in,
        output px_shade_in,
        output palette_in,
        output vblank_in,
        input  px_ready_out,
        input  fb_en_out,
        input  fb_we_out,
        input  fb_addr_out,
        input  fb_din_out,
        input  display_bank_out,
        input  frame_count_out
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Maps PPU shades through the DMG palette and writes them into the back bank
// of a double-buffered frame buffer; banks swap only during vblank.
module fb_pixel_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_PIXELS = 144,
    parameter int ADDR_W   = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    fb_pixel_writer_if.slave   bus
);
    localparam int FRAME = H_PIXELS * V_PIXELS;
    localparam int X_W   = $clog2(H_PIXELS);
    localparam int Y_W   = $clog2(V_PIXELS + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_SWAP
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_pending;
    logic              r_bank;
    logic [7:0]        r_count;
    logic              r_en;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [14:0]       r_din;

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_wr_base;
    logic [ADDR_W-1:0] w_swap_base;
    logic [1:0]        w_cidx;
    logic [14:0]       w_colour;

    assign w_accept = bus.px_valid_in & r_ready;
    assign w_last   = (r_x == X_W'(H_PIXELS - 1)) &&
                      (r_y == Y_W'(V_PIXELS - 1));

    // Write bank is the one not being displayed.
    assign w_wr_base   = r_bank ? '0 : ADDR_W'(FRAME);
    // After the toggle, the old display bank becomes the write bank.
    assign w_swap_base = r_bank ? ADDR_W'(FRAME) : '0;

    assign w_cidx = bus.palette_in[{bus.px_shade_in, 1'b0} +: 2];

    // DMG colour index to RGB555 grey level.
    always_comb begin
        w_colour = 15'h7FFF;
        unique case (w_cidx)
            2'd0: w_colour = 15'h7FFF;
            2'd1: w_colour = 15'h56B5;
            2'd2: w_colour = 15'h294A;
            2'd3: w_colour = 15'h0000;
            default: w_colour = 15'h7FFF;
        endcase
    end

    // Control FSM, raster pointer and registered write port.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_ptr     <= '0;
            r_pending <= 1'b0;
            r_bank    <= 1'b0;
            r_count   <= '0;
            r_en      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
        end else begin
            r_en <= w_accept;
            r_we <= w_accept;
            if (w_accept) begin
                r_addr <= r_ptr;
                r_din  <= w_colour;
                r_ptr  <= r_ptr + 1'b1;
                if (r_x == X_W'(H_PIXELS - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.frame_start_in) begin
                        r_state <= WRITE;
                        r_ready <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_ptr   <= w_wr_base;
                    end
                end
                WRITE: begin
                    // A restart wins over the pointer advance; the pixel
                    // accepted this cycle already took the old address.
                    if (bus.frame_start_in) begin
                        r_x   <= '0;
                        r_y   <= '0;
                        r_ptr <= w_wr_base;
                    end else if (w_accept && w_last) begin
                        r_state <= WAIT_SWAP;
                        r_ready <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    if (bus.frame_start_in) begin
                        r_pending <= 1'b1;
                    end
                    if (bus.vblank_in) begin
                        r_bank    <= ~r_bank;
                        r_count   <= r_count + 1'b1;
                        r_pending <= 1'b0;
                        if (r_pending || bus.frame_start_in) begin
                            r_state <= WRITE;
                            r_ready <= 1'b1;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_ptr   <= w_swap_base;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.px_ready_out     = r_ready;
    assign bus.fb_en_out        = r_en;
    assign bus.fb_we_out        = r_we;
    assign bus.fb_addr_out      = r_addr;
    assign bus.fb_din_out       = r_din;
    assign bus.display_bank_out = r_bank;
    assign bus.frame_count_out  = r_count;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: driver queues expected writes,
// a negedge monitor pops and compares every frame buffer write.
module tb_fb_pixel_writer;
    localparam int H  = 160;
    localparam int V  = 144;
    localparam int FR = H * V;

    typedef struct {
        int addr;
        int din;
        int cyc;
        bit lit_chk;
        int lit_addr;
        int lit_din;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    fb_pixel_writer_if #(.ADDR_W(16)) bus ();

    fb_pixel_writer #(
        .H_PIXELS(H),
        .V_PIXELS(V),
        .ADDR_W(16)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc     = 0;
    int nwr     = 0;
    int bx      = 0;
    int by      = 0;
    int exp_bank = 0;
    logic [7:0] pal;
    exp_t q[$];
    exp_t m;

    bit lit_arm = 0;
    int lit_x, lit_y, lit_addr, lit_din;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int colour(input logic [7:0] p, input logic [1:0] s);
        logic [7:0] t;
        t = p >> (2 * s);
        case (t[1:0])
            2'd0: return 32'h7FFF;
            2'd1: return 32'h56B5;
            2'd2: return 32'h294A;
            default: return 32'h0000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic arm(input int x, input int y, input int a, input int d);
        lit_arm = 1;
        lit_x = x;
        lit_y = y;
        lit_addr = a;
        lit_din = d;
    endtask

    task automatic step(input bit v, input logic [1:0] s, input bit fs);
        exp_t e;
        @(negedge clk_in);
        bus.px_valid_in    = v;
        bus.px_shade_in    = s;
        bus.frame_start_in = fs;
        bus.palette_in     = pal;
        if (v && bus.px_ready_out) begin
            e.addr = (exp_bank != 0 ? 0 : FR) + by * H + bx;
            e.din  = colour(pal, s);
            e.cyc  = cyc + 1;
            e.lit_chk = 0;
            e.lit_addr = 0;
            e.lit_din = -1;
            if (lit_arm && bx == lit_x && by == lit_y) begin
                e.lit_chk = 1;
                e.lit_addr = lit_addr;
                e.lit_din = lit_din;
                lit_arm = 0;
            end
            q.push_back(e);
            acc++;
            if (bx == H - 1) begin
                bx = 0;
                by++;
            end else begin
                bx++;
            end
        end
        if (fs) begin
            bx = 0;
            by = 0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, int'(bus.px_ready_out), 0);
        check({tag, "_en"}, int'(bus.fb_en_out), 0);
        check({tag, "_we"}, int'(bus.fb_we_out), 0);
        check({tag, "_addr"}, int'(bus.fb_addr_out), 0);
        check({tag, "_din"}, int'(bus.fb_din_out), 0);
        check({tag, "_bank"}, int'(bus.display_bank_out), 0);
        check({tag, "_count"}, int'(bus.frame_count_out), 0);
    endtask

    always @(negedge clk_in) begin
        if (bus.fb_en_out || bus.fb_we_out) begin
            nwr++;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0d din %0h, no write expected",
                         bus.fb_addr_out, bus.fb_din_out);
            end else begin
                m = q.pop_front();
                if (!(bus.fb_en_out && bus.fb_we_out) ||
                    int'(bus.fb_addr_out) != m.addr ||
                    int'(bus.fb_din_out) != m.din || cyc != m.cyc) begin
                    n_fail++;
                    $display("FAIL write: en/we %b%b addr %0d din %0h cyc %0d, expected addr %0d din %0h cyc %0d",
                             bus.fb_en_out, bus.fb_we_out, bus.fb_addr_out,
                             bus.fb_din_out, cyc, m.addr, m.din, m.cyc);
                end
                if (m.lit_chk) begin
                    check("lit_addr", int'(bus.fb_addr_out), m.lit_addr);
                    if (m.lit_din >= 0)
                        check("lit_din", int'(bus.fb_din_out), m.lit_din);
                end
            end
        end
    end

    initial begin
        int acc0;
        int nwr0;
        bit armed2;
        pal = 8'hE4;
        bus.frame_start_in = 0;
        bus.px_valid_in = 0;
        bus.px_shade_in = 0;
        bus.palette_in = pal;
        bus.vblank_in = 0;

        repeat (3) @(negedge clk_in);
        check_reset_vals("reset");
        @(negedge clk_in);
        rst_in = 0;

        repeat (5) step(1, 2'd1, 0);
        check("idle_ready", int'(bus.px_ready_out), 0);

        step(0, 2'd0, 1);
        for (int g = 0; g < 30000 && acc < FR; g++) step(1, 2'd1, 0);
        check("frame1_accepts", acc, FR);

        for (int i = 0; i < 100; i++) begin
            step(1, 2'd2, 0);
            check("stall_ready", int'(bus.px_ready_out), 0);
            check("stall_bank", int'(bus.display_bank_out), 0);
        end
        step(0, 2'd0, 0);
        bus.vblank_in = 1;
        @(negedge clk_in);
        check("swap1_bank", int'(bus.display_bank_out), 1);
        check("swap1_count", int'(bus.frame_count_out), 1);
        check("swap1_ready", int'(bus.px_ready_out), 0);
        repeat (8) @(negedge clk_in);
        check("long_vblank_bank", int'(bus.display_bank_out), 1);
        check("long_vblank_count", int'(bus.frame_count_out), 1);
        bus.vblank_in = 0;
        exp_bank = 1;

        pal = 8'h1B;
        arm(0, 0, 0, 0);
        armed2 = 0;
        acc0 = acc;
        nwr0 = nwr;
        step(0, 2'd0, 1);
        for (int g = 0; g < 60000 && acc - acc0 < FR; g++) begin
            if (!armed2 && acc - acc0 == 1) begin
                arm(5, 2, 325, -1);
                armed2 = 1;
            end
            if (acc - acc0 == 10000) pal = 8'hE4;
            step($urandom_range(0, 3) != 0, 2'(acc - acc0), 0);
        end
        check("frame2_accepts", acc - acc0, FR);
        step(0, 2'd0, 0);
        step(0, 2'd0, 0);
        check("frame2_we_count", nwr - nwr0, acc - acc0);

        step(0, 2'd0, 1);
        step(0, 2'd0, 0);
        check("pend_ready", int'(bus.px_ready_out), 0);
        check("pend_bank", int'(bus.display_bank_out), 1);
        bus.vblank_in = 1;
        @(negedge clk_in);
        bus.vblank_in = 0;
        check("swap2_bank", int'(bus.display_bank_out), 0);
        check("swap2_count", int'(bus.frame_count_out), 2);
        check("swap2_ready", int'(bus.px_ready_out), 1);
        exp_bank = 0;

        acc0 = acc;
        for (int g = 0; g < 1000 && acc - acc0 < 500; g++) step(1, 2'd3, 0);
        step(0, 2'd0, 1);
        arm(0, 0, FR, -1);
        acc0 = acc;
        for (int g = 0; g < 2000 && acc - acc0 < 1000; g++)
            step(1, 2'(g), 0);
        step(0, 2'd0, 0);
        step(0, 2'd0, 0);
        check("pre_reset_queue", q.size(), 0);

        #2 rst_in = 1;
        #1 check_reset_vals("async_reset");
        @(negedge clk_in);
        rst_in = 0;
        repeat (10) step(1, 2'd1, 0);
        check("post_reset_ready", int'(bus.px_ready_out), 0);
        check("post_reset_queue", q.size(), 0);

        pal = 8'hE4;
        step(0, 2'd0, 1);
        arm(0, 0, FR, 16'h7FFF);
        repeat (3) step(1, 2'd0, 0);
        step(0, 2'd0, 0);
        step(0, 2'd0, 0);
        check("final_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Upstream stage of the dual-port frame buffer.
- Accepts the PPU's raster-ordered 2-bit shade stream over a valid/ready handshake and maps each shade through the DMG palette to an RGB555 colour.
- Writes the colour into the back half of a 2×160×144 double-buffered frame buffer through one write port.
- Swaps front/back banks only during display vblank, so scan-out never shows a torn frame.

Parameters:
- H_PIXELS, 160, pixels per line
- V_PIXELS, 144, lines per frame
- ADDR_W, 16, frame buffer address width; must hold 2*H_PIXELS*V_PIXELS-1 = 46079

Ports:
- clk_in  input  1  system clock; everything is in this domain
- rst_in  input  1  asynchronous, active-high reset
- frame_start_in  input  1  one-cycle pulse from PPU at the start of a new frame
- px_valid_in  input  1  PPU shade valid
- px_shade_in  input  2  DMG shade index 0..3
- px_ready_out  output  1  writer can accept a pixel this cycle
- palette_in  input  8  BGP register; bits [2k+1:2k] give the colour index for shade k
- vblank_in  input  1  display side is in vblank (already synchronous to clk_in)
- fb_en_out  output  1  frame buffer port enable
- fb_we_out  output  1  frame buffer write enable
- fb_addr_out  output  ADDR_W  frame buffer write address
- fb_din_out  output  15  RGB555 write data
- display_bank_out  output  1  bank scan-out must read; base address = bank*H_PIXELS*V_PIXELS
- frame_count_out  output  8  completed-and-swapped frame counter, wraps at 255→0

Behaviour:
- Reset (async, active-high) values:
  - state IDLE; px_ready_out 0
  - fb_en_out, fb_we_out, fb_addr_out, fb_din_out all 0
  - display_bank_out 0; frame_count_out 0
  - x, y, write pointer 0; pending_start 0
- Reset asserted mid-frame discards the partial frame. After reset release, nothing is written until the next frame_start_in.
- Write bank is always ~display_bank_out. Write base is 0 for bank 0 and H_PIXELS*V_PIXELS (23040) for bank 1.
- Address is generated by an incrementing pointer, not a multiplier:
  - pointer = base at frame start
  - pointer increments by 1 per accepted pixel
  - x counts 0..H_PIXELS-1; y increments when x wraps
- Colour map: colour index c = palette_in[2*shade+1 : 2*shade]. c maps to 0→15'h7FFF, 1→15'h56B5, 2→15'h294A, 3→15'h0000.
- Palette is sampled in the acceptance cycle; a palette change affects only pixels accepted after it.
- px_ready_out is registered and equals (state==WRITE). A pixel is accepted when px_valid_in & px_ready_out.
- Latency: pixel accepted at cycle N gives fb_en_out=fb_we_out=1 with its addr/din during cycle N+1. Both enables are 0 in cycles following no acceptance. No read is ever issued.
- States:
  - IDLE: frame_start_in → WRITE, with x=y=0 and pointer=write base.
  - WRITE: accepting pixels. Acceptance of pixel (H_PIXELS-1, V_PIXELS-1) → WAIT_SWAP.
    - frame_start_in while in WRITE (short/aborted frame) restarts x=y=0 and pointer=write base in the same bank. Partial data is simply overwritten.
    - A pixel accepted in the same cycle as frame_start_in is written at the pre-restart address. Restart takes effect the next cycle.
  - WAIT_SWAP: px_ready_out=0. Any frame_start_in sets pending_start. When vblank_in=1, toggle display_bank_out and increment frame_count_out. Then go to WRITE (restarting at the new write base) if pending_start, else IDLE; pending_start clears.
    - The last pixel's write (cycle N+1) always lands in the first WAIT_SWAP cycle, before the swap in the earliest possible following cycle.
- vblank_in is level-sensitive. A long vblank causes one swap only, because the state leaves WAIT_SWAP.
- If vblank_in never asserts, the writer stalls in WAIT_SWAP and backpressures the PPU. No overwrite of the displayed bank ever occurs.

Test Plan:
- Reset, frame_start_in, then 23040 valid pixels of shade 1 with palette_in=8'hE4 → 23040 writes at addresses 23040..46079 (write bank 1), din 15'h56B5, each one cycle after acceptance.
- After the frame completes, hold vblank_in=0 for 100 cycles → px_ready_out stays 0, display_bank_out stays 0. Raise vblank_in → next cycle display_bank_out=1, frame_count_out=1, state IDLE.
- Second frame → writes at addresses 0..23039. Verify pixel (x=5, y=2) is at address 325. Palette 8'h1B with shade 0 → din 15'h0000.
- Random px_valid_in gaps → address sequence contiguous with no skips/duplicates, and fb_we_out count equals accepted count.
- frame_start_in after 500 pixels → next accepted pixel writes the write-bank base address. frame_start_in during WAIT_SWAP → after the swap, goes directly to WRITE with px_ready_out=1.
- Assert rst_in mid-frame at pixel 1000 → all outputs return to reset values asynchronously. Pixels presented before the next frame_start_in produce no writes.
